char_glyph_serializer: RTL and testbench
========================================

// Module: char_glyph_serializer
//
// PURPOSE
// Consumer of the char_rom font BRAM. Accepts (char code, glyph row, colours)
// requests, drives the char_rom ADDR as {code,row}, captures the 16-bit DO and
// serializes it MSB-first into a coloured pixel stream on pix_clk. A one-entry
// prefetch buffer gives gapless output for back-to-back glyphs of one text line.
//
// PARAMETERS
// GLYPH_W   16  pixels shifted out per glyph row (DO[15] first); 1..16
// ROM_LAT   1   cycles from ADDR edge to valid DO (1 = no DO register)
// COLOR_W   12  width of fg/bg/pixel colour (4:4:4 RGB)
//
// PORTS
// pix_clk     in   1        pixel clock, all logic rising-edge
// rst         in   1        synchronous, active-high reset
// req_valid   in   1        request present
// req_ready   out  1        request accepted when req_valid && req_ready
// req_code    in   7        ASCII code (0..127)
// req_row     in   4        glyph row (0..15)
// req_fg      in   COLOR_W  colour for '1' bits
// req_bg      in   COLOR_W  colour for '0' bits
// rom_addr    out  11       to char_rom ADDR; EN tied 1, WE 0 at integration
// rom_do      in   16       from char_rom DO
// pix_valid   out  1        pix_rgb carries a pixel this cycle
// pix_rgb     out  COLOR_W  pixel colour
// pix_last    out  1        high with last pixel of a glyph row
//
// BEHAVIOUR
// - Reset: req_ready 0 in reset cycle then 1; rom_addr 0; pix_valid 0;
//   pix_rgb 0; pix_last 0; fetch idle; prefetch buffer empty; shifter empty.
//   Reset mid-glyph aborts: pixels stop next cycle, pending fetch discarded.
// - Fetch FSM: F_IDLE -> F_ADDR -> F_WAIT(ROM_LAT cycles) -> F_IDLE.
//   Accept (cycle T): registers rom_addr <= {req_code,req_row} (valid T+1),
//   latches fg/bg. DO captured into prefetch buffer at end of cycle T+1+ROM_LAT.
//   rom_addr holds its last value while idle.
// - req_ready = fetch FSM in F_IDLE && prefetch buffer empty && !rst.
//   At most one fetch outstanding; req_* ignored when not accepted.
// - Shifter: loads prefetch buffer (bits, fg, bg) when shifter empty or on the
//   cycle its last pixel is output; buffer marked empty that same edge (a
//   simultaneous capture into the buffer wins: buffer stays full with new data).
// - Output: one pixel per cycle for GLYPH_W cycles; pixel i (i=0..GLYPH_W-1)
//   uses bit DO[15-i]; pix_rgb = bit ? fg : bg; pix_last on i=GLYPH_W-1.
//   No output backpressure.
// - Latency (ROM_LAT=1): accept at T -> first pix_valid at T+3.
// - Gapless: with a request accepted no later than GLYPH_W-(2+ROM_LAT)
//   cycles into the previous glyph, pixel streams abut with no pix_valid gap.
// - Empty: shifter and buffer empty -> pix_valid 0, pix_rgb 0, pix_last 0.
// - Pixel counter width ceil(log2(GLYPH_W+1)); no wrap beyond GLYPH_W.
//
// TESTING (bench uses behavioural char_rom model, latency ROM_LAT)
// 1 Reset then req 'A'(65) row 3, ROM[1043]=16'h1818, fg FFF bg 000 at T ->
//   rom_addr=11'd1043 at T+1; pix_valid T+3..T+18; rgb 000 x3,FFF x2,000 x6,
//   FFF x2,000 x3; pix_last only at T+18.
// 2 Back-to-back: 'A' rows 0..15 with req_valid held high -> 256 contiguous
//   pix_valid cycles, pix_last every 16th, addresses 1040..1055 in order.
// 3 Stall: second request presented while buffer full -> req_ready 0 until
//   buffer loads into shifter; request held stable and accepted exactly once.
// 4 Reset mid-glyph: assert rst at pixel 7 of code 0x7F row 15 -> next cycle
//   pix_valid 0, pix_rgb 0, rom_addr 0; post-reset request behaves as test 1.
// 5 Edge codes: code 0 row 0 (addr 0) and code 127 row 15 (addr 2047),
//   DO 16'h8001 -> fg on first and last pixel only.
// 6 ROM_LAT=2 build: repeat tests 1-2 -> first pixel at T+4, still gapless.

Source files
------------

// File: rtl/char_glyph_serializer.sv
// ---------------------------------------------------------------------------
// char_glyph_serializer
//
// Turns (char code, glyph row, colours) requests into a coloured pixel
// stream. Each request fetches one 16-bit glyph row from the char_rom font
// BRAM at address {code,row}. The row is serialized MSB-first as GLYPH_W
// pixels, one per pix_clk cycle. A one-entry prefetch buffer sits between
// the fetch and the shifter. It lets the next glyph row arrive while the
// current one is still being shifted out, so back-to-back glyphs of a text
// line come out without gaps.
//
// Ports:
//   pix_clk    pixel clock; all logic uses the rising edge
//   rst        synchronous, active-high reset
//   req_valid  a request is present
//   req_ready  the request is accepted when req_valid && req_ready
//   req_code   ASCII code (7 bits)
//   req_row    glyph row (4 bits)
//   req_fg     colour used for '1' bits
//   req_bg     colour used for '0' bits
//   rom_addr   char_rom ADDR = {code,row}; holds its last value while idle
//   rom_do     char_rom DO; valid ROM_LAT cycles after rom_addr
//   pix_valid  pix_rgb carries a pixel this cycle
//   pix_rgb    pixel colour (0 when no pixel is shown)
//   pix_last   high together with the last pixel of a glyph row
// ---------------------------------------------------------------------------
module char_glyph_serializer #(
    parameter int GLYPH_W = 16,
    parameter int ROM_LAT = 1,
    parameter int COLOR_W = 12
) (
    input  logic               pix_clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [6:0]         req_code,
    input  logic [3:0]         req_row,
    input  logic [COLOR_W-1:0] req_fg,
    input  logic [COLOR_W-1:0] req_bg,
    output logic [10:0]        rom_addr,
    input  logic [15:0]        rom_do,
    output logic               pix_valid,
    output logic [COLOR_W-1:0] pix_rgb,
    output logic               pix_last
);

    localparam int CNT_W = $clog2(GLYPH_W + 1);
    localparam int LAT_W = $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {
        F_IDLE,
        F_ADDR,
        F_WAIT
    } fetch_state_e;

    fetch_state_e       fetch_q, fetch_d;
    logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [10:0]        rom_addr_q, rom_addr_d;
    logic [COLOR_W-1:0] pend_fg_q, pend_fg_d;     // colours of the fetch in flight
    logic [COLOR_W-1:0] pend_bg_q, pend_bg_d;
    logic               buf_full_q, buf_full_d;
    logic [15:0]        buf_bits_q, buf_bits_d;
    logic [COLOR_W-1:0] buf_fg_q, buf_fg_d;
    logic [COLOR_W-1:0] buf_bg_q, buf_bg_d;
    logic [15:0]        shift_bits_q, shift_bits_d;
    logic [COLOR_W-1:0] shift_fg_q, shift_fg_d;
    logic [COLOR_W-1:0] shift_bg_q, shift_bg_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;     // pixels still to output

    logic accept;
    logic capture;
    logic shift_free;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        fetch_d      = fetch_q;
        wait_cnt_d   = wait_cnt_q;
        rom_addr_d   = rom_addr_q;
        pend_fg_d    = pend_fg_q;
        pend_bg_d    = pend_bg_q;
        buf_full_d   = buf_full_q;
        buf_bits_d   = buf_bits_q;
        buf_fg_d     = buf_fg_q;
        buf_bg_d     = buf_bg_q;
        shift_bits_d = shift_bits_q;
        shift_fg_d   = shift_fg_q;
        shift_bg_d   = shift_bg_q;
        pix_cnt_d    = pix_cnt_q;

        req_ready = (fetch_q == F_IDLE) && !buf_full_q && !rst;
        accept    = req_valid && req_ready;
        // DO is valid during the last F_WAIT cycle.
        capture   = (fetch_q == F_WAIT) && (wait_cnt_q == LAT_W'(1));

        // Fetch FSM: one fetch outstanding at most.
        unique case (fetch_q)
            F_IDLE: begin
                if (accept) begin
                    rom_addr_d = {req_code, req_row};
                    pend_fg_d  = req_fg;
                    pend_bg_d  = req_bg;
                    fetch_d    = F_ADDR;
                end
            end
            F_ADDR: begin
                wait_cnt_d = LAT_W'(ROM_LAT);
                fetch_d    = F_WAIT;
            end
            F_WAIT: begin
                wait_cnt_d = wait_cnt_q - LAT_W'(1);
                if (capture) fetch_d = F_IDLE;
            end
            default: fetch_d = F_IDLE;
        endcase

        // Shifter advances one pixel per cycle while it holds a row.
        if (pix_cnt_q != '0) begin
            shift_bits_d = {shift_bits_q[14:0], 1'b0};
            pix_cnt_d    = pix_cnt_q - CNT_W'(1);
        end

        // The shifter can take a new row when it is empty, or in the same
        // cycle its last pixel goes out.
        shift_free = (pix_cnt_q == '0) || (pix_cnt_q == CNT_W'(1));

        if (shift_free && buf_full_q) begin
            shift_bits_d = buf_bits_q;
            shift_fg_d   = buf_fg_q;
            shift_bg_d   = buf_bg_q;
            pix_cnt_d    = CNT_W'(GLYPH_W);
            buf_full_d   = 1'b0;
        end else if (shift_free && capture) begin
            // The buffer is empty, so the captured row passes straight through
            // it into the shifter on the same edge. This is what gives the
            // first pixel one cycle after DO is captured.
            shift_bits_d = rom_do;
            shift_fg_d   = pend_fg_q;
            shift_bg_d   = pend_bg_q;
            pix_cnt_d    = CNT_W'(GLYPH_W);
        end

        // A capture on the same edge as a buffer unload wins: the buffer stays full.
        if (capture && !(shift_free && !buf_full_q)) begin
            buf_bits_d = rom_do;
            buf_fg_d   = pend_fg_q;
            buf_bg_d   = pend_bg_q;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge pix_clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the values from before the edge.
        if (rst) begin
            fetch_q      <= F_IDLE;
            wait_cnt_q   <= '0;
            rom_addr_q   <= '0;
            pend_fg_q    <= '0;
            pend_bg_q    <= '0;
            buf_full_q   <= 1'b0;
            buf_bits_q   <= '0;
            buf_fg_q     <= '0;
            buf_bg_q     <= '0;
            shift_bits_q <= '0;
            shift_fg_q   <= '0;
            shift_bg_q   <= '0;
            pix_cnt_q    <= '0;
        end else begin
            fetch_q      <= fetch_d;
            wait_cnt_q   <= wait_cnt_d;
            rom_addr_q   <= rom_addr_d;
            pend_fg_q    <= pend_fg_d;
            pend_bg_q    <= pend_bg_d;
            buf_full_q   <= buf_full_d;
            buf_bits_q   <= buf_bits_d;
            buf_fg_q     <= buf_fg_d;
            buf_bg_q     <= buf_bg_d;
            shift_bits_q <= shift_bits_d;
            shift_fg_q   <= shift_fg_d;
            shift_bg_q   <= shift_bg_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_valid = (pix_cnt_q != '0);
    assign pix_rgb   = pix_valid ? (shift_bits_q[15] ? shift_fg_q : shift_bg_q) : '0;
    assign pix_last  = (pix_cnt_q == CNT_W'(1));

endmodule

// File: tb/tb_char_glyph_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for char_glyph_serializer.
//
// A behavioural char_rom model has ROM_LAT cycles of address-to-data latency.
// Each accepted request pushes its expected pixels onto a scoreboard queue.
// The pixels are derived from the ROM contents and the request colours. The
// queue is popped whenever pix_valid is seen. Rebuild with ROM_LAT=2 to cover
// the two-cycle ROM.
// ---------------------------------------------------------------------------
module tb_char_glyph_serializer;

    parameter int ROM_LAT = 1;
    localparam int GLYPH_W = 16;
    localparam int COLOR_W = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [6:0]         req_code;
    logic [3:0]         req_row;
    logic [COLOR_W-1:0] req_fg;
    logic [COLOR_W-1:0] req_bg;
    logic [10:0]        rom_addr;
    logic [15:0]        rom_do;
    logic               pix_valid;
    logic [COLOR_W-1:0] pix_rgb;
    logic               pix_last;

    always #5 clk = ~clk;

    char_glyph_serializer #(
        .GLYPH_W(GLYPH_W),
        .ROM_LAT(ROM_LAT),
        .COLOR_W(COLOR_W)
    ) dut (
        .pix_clk   (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_row   (req_row),
        .req_fg    (req_fg),
        .req_bg    (req_bg),
        .rom_addr  (rom_addr),
        .rom_do    (rom_do),
        .pix_valid (pix_valid),
        .pix_rgb   (pix_rgb),
        .pix_last  (pix_last)
    );

    // ---------------- behavioural char_rom ----------------
    function automatic logic [15:0] rom_word(input logic [10:0] a);
        logic [31:0] t;
        if (a == 11'd1043) return 16'h1818;
        if (a == 11'd0 || a == 11'd2047) return 16'h8001;
        t = {21'd0, a} * 32'd40503;
        return t[15:0] ^ 16'hA5C3;
    endfunction

    logic [15:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_do = rom_pipe[ROM_LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [COLOR_W-1:0] rgb;
        logic               last;
    } pix_t;

    pix_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_last   = 0;
    int          run_len  = 0;
    int          last_run = 0;
    logic        addr_pend = 1'b0;
    logic [10:0] addr_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        pix_t        e;
        logic [15:0] w;
        if (addr_pend) begin
            check("rom_addr", 32'(rom_addr), 32'(addr_exp));
            addr_pend = 1'b0;
        end
        if (pix_valid) begin
            run_len++;
            if (pix_last) n_last++;
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
                check("pix_last", 32'(pix_last), 32'(e.last));
            end
        end else begin
            if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            check("idle_out", {19'd0, pix_rgb, pix_last}, 32'd0);
        end
        if (rst) begin
            exp_q.delete();
            addr_pend = 1'b0;
        end else if (req_valid && req_ready) begin
            n_acc++;
            addr_pend = 1'b1;
            addr_exp  = {req_code, req_row};
            w = rom_word({req_code, req_row});
            for (int i = 0; i < GLYPH_W; i++) begin
                e.rgb  = w[15-i] ? req_fg : req_bg;
                e.last = (i == GLYPH_W - 1);
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a request and hold it until accepted. Leaves req_valid high so
    // that consecutive calls keep it asserted. t = cycle of acceptance.
    task automatic send_req(input logic [6:0] code, input logic [3:0] row,
                            input logic [COLOR_W-1:0] fg, input logic [COLOR_W-1:0] bg,
                            output int t);
        bit ok = 1'b0;
        t = -1;
        req_code  = code;
        req_row   = row;
        req_fg    = fg;
        req_bg    = bg;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic release_req();
        req_valid = 1'b0;
        req_code  = $urandom_range(0, 127);
        req_row   = $urandom_range(0, 15);
    endtask

    task automatic wait_pix(output int c);
        bit ok = 1'b0;
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pix_valid) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("pix_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!pix_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Single glyph 'A' row 3, with first-pixel latency check.
    task automatic single_a_row3();
        int t, c, l0;
        l0 = n_last;
        send_req(7'd65, 4'd3, 12'hFFF, 12'h000, t);
        release_req();
        wait_pix(c);
        check("first_pix_latency", 32'(c - t), 32'(ROM_LAT + 2));
        drain();
        check("single_glyph_lasts", 32'(n_last - l0), 32'd1);
        check("single_glyph_run", 32'(last_run), 32'(GLYPH_W));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t1, t2, t3, c, l0, a0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_code  = '0;
        req_row   = '0;
        req_fg    = '0;
        req_bg    = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        check("rom_addr_reset", 32'(rom_addr), 32'd0);
        check("pix_valid_reset", 32'(pix_valid), 32'd0);
        @(posedge clk);
        #1;

        // 1: single glyph row.
        single_a_row3();

        // 2: 'A' rows 0..15 back to back, req_valid held high.
        l0 = n_last;
        for (int r = 0; r < 16; r++) send_req(7'd65, 4'(r), 12'h0F0, 12'h111, t1);
        release_req();
        drain();
        check("b2b_run_len", 32'(last_run), 32'(16 * GLYPH_W));
        check("b2b_lasts", 32'(n_last - l0), 32'd16);

        // 3: stall while the prefetch buffer is full.
        l0 = n_last;
        a0 = n_acc;
        send_req(7'd66, 4'd1, 12'hABC, 12'h321, t1);
        send_req(7'd67, 4'd2, 12'h00F, 12'hF00, t2);
        check("second_accept", 32'(t2 - t1), 32'(ROM_LAT + 2));
        send_req(7'd68, 4'd4, 12'h5A5, 12'hA5A, t3);
        check("stalled_accept", 32'(t3 - t1), 32'(ROM_LAT + 2 + GLYPH_W));
        release_req();
        drain();
        check("stall_accept_count", 32'(n_acc - a0), 32'd3);
        check("stall_lasts", 32'(n_last - l0), 32'd3);

        // 4: reset in the middle of a glyph, at pixel 7.
        l0 = n_last;
        send_req(7'h7F, 4'd15, 12'hFFF, 12'h000, t1);
        release_req();
        wait_pix(c);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_in_mid_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_pix_valid", 32'(pix_valid), 32'd0);
        check("abort_pix_rgb", 32'(pix_rgb), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("abort_lasts", 32'(n_last - l0), 32'd0);
        single_a_row3();

        // 5: edge codes, DO 16'h8001 -> fg only on first and last pixel.
        l0 = n_last;
        send_req(7'd0, 4'd0, 12'h0F0, 12'h00F, t1);
        send_req(7'd127, 4'd15, 12'hF00, 12'h0FF, t2);
        release_req();
        drain();
        check("edge_lasts", 32'(n_last - l0), 32'd2);
        check("edge_run_len", 32'(last_run), 32'(2 * GLYPH_W));

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
